muldiv_unit: RTL

Parametrised iterative multiply/divide unit for the EX stage. It executes MIPS MULT, MULTU, DIV and DIVU on WIDTH-bit operands and returns a 2·WIDTH-bit {HI, LO} result. It replaces the separate fixed-width multiplier and divider with a single shared datapath. It adds an explicit start/busy/ready handshake, annul (flush) support, fixed latency for every op, and a divide-by-zero flag. EX drives it and holds its own stall request while `busy_o` is high.

---
 rtl/muldiv_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for MIPS MULT/MULTU/DIV/DIVU.
// A single shared 2*WIDTH accumulator runs shift-add or restoring division, with a fixed latency.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 div_by_zero_o
);

    // Handshake: a request is taken on a rising edge where the unit is IDLE, start_i=1 and annul_i=0.
    // ready_o is a one-cycle pulse with result_o valid. busy_o is high from accept through the ready cycle.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               op_div, op_signed, sign1, sign2, dbz;

    logic               accept, last;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] acc_step, fix_result;
    logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;
    logic               neg;

    assign accept = (state == S_IDLE) && start_i && !annul_i;
    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign abs1   = (op_i[0] && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign abs2   = (op_i[0] && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_RUN;
            S_RUN: begin
                if (annul_i)   state_nx = S_IDLE;
                else if (last) state_nx = S_FIX;
            end
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // One iteration: multiply keeps the multiplier in the low half and the partial product in the high half;
    // divide keeps {remainder, dividend/quotient} and shifts quotient bits in from the right.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opb};
        if (op_div) begin
            if (div_diff[WIDTH]) acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else                 acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction is applied to the final iteration's value so the result can be registered on entry to FIX.
    always_comb begin
        neg     = op_signed && (sign1 ^ sign2);
        quo     = acc_step[WIDTH-1:0];
        rem     = acc_step[2*WIDTH-1:WIDTH];
        quo_fix = dbz ? '1 : (neg ? -quo : quo);
        rem_fix = (op_signed && sign1) ? -rem : rem;
        if (op_div) fix_result = {rem_fix, quo_fix};
        else        fix_result = neg ? -acc_step : acc_step;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_o        <= 1'b0;
            ready_o       <= 1'b0;
            result_o      <= '0;
            div_by_zero_o <= 1'b0;
            cnt           <= '0;
            acc           <= '0;
            opb           <= '0;
            op_div        <= 1'b0;
            op_signed     <= 1'b0;
            sign1         <= 1'b0;
            sign2         <= 1'b0;
            dbz           <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        busy_o    <= 1'b1;
                        cnt       <= '0;
                        op_div    <= op_i[1];
                        op_signed <= op_i[0];
                        sign1     <= opdata1_i[WIDTH-1];
                        sign2     <= opdata2_i[WIDTH-1];
                        dbz       <= op_i[1] && (opdata2_i == '0);
                        acc       <= {{WIDTH{1'b0}}, abs1};
                        opb       <= abs2;
                    end
                end
                S_RUN: begin
                    if (annul_i) begin
                        busy_o <= 1'b0;
                    end else begin
                        acc <= acc_step;
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            result_o      <= fix_result;
                            div_by_zero_o <= dbz;
                            ready_o       <= 1'b1;
                        end
                    end
                end
                S_FIX:   busy_o <= 1'b0;
                default: busy_o <= 1'b0;
            endcase
        end
    end

endmodule
